// File: rtl/ps2_rx_fifo_if.sv
// Decoder-side bundle of the PS/2 receiver: frame enable, FIFO read port and status pulses.
// The receiver takes the slave view; the scan-code decoder takes the master view.
interface ps2_rx_fifo_if;
  logic       rx_en;
  logic       rd_en;
  logic [7:0] dout;
  logic       empty;
  logic       full;
  logic       rx_busy;
  logic       parity_err;
  logic       frame_err;
  logic       timeout_err;
  logic       overflow;

  modport master (
    output rx_en,
    output rd_en,
    input  dout,
    input  empty,
    input  full,
    input  rx_busy,
    input  parity_err,
    input  frame_err,
    input  timeout_err,
    input  overflow
  );

  modport slave (
    input  rx_en,
    input  rd_en,
    output dout,
    output empty,
    output full,
    output rx_busy,
    output parity_err,
    output frame_err,
    output timeout_err,
    output overflow
  );
endinterface

// File: rtl/ps2_rx_fifo.sv
// PS/2 device-to-host receiver: synchronise and deglitch the pins, deserialise 11-bit frames,
// check stop/parity/inter-edge timing, and buffer good bytes in a show-ahead FIFO.
module ps2_rx_fifo #(
  parameter int unsigned FILTER_LEN  = 8,
  parameter int unsigned TIMEOUT_CYC = 50000,
  parameter int unsigned FIFO_DEPTH  = 4,
  parameter int unsigned CNT_W       = 16
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              ps2d,
  input  logic              ps2c,
  ps2_rx_fifo_if.slave      bus
);

  localparam int unsigned PTR_W = $clog2(FIFO_DEPTH);
  localparam int unsigned OCC_W = PTR_W + 1;

  typedef enum logic [1:0] {
    StIdle,
    StData,
    StCheck
  } state_e;

  // Input synchronisers and ps2c deglitch filter
  logic                  ps2c_meta, ps2c_s;
  logic                  ps2d_meta, ps2d_s;
  logic [FILTER_LEN-1:0] filter_q;
  logic                  f_ps2c_q;
  logic                  f_ps2c_d;
  logic                  fall_edge;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      ps2c_meta <= 1'b1;
      ps2c_s    <= 1'b1;
      ps2d_meta <= 1'b1;
      ps2d_s    <= 1'b1;
      filter_q  <= '1;
      f_ps2c_q  <= 1'b1;
    end else begin
      ps2c_meta <= ps2c;
      ps2c_s    <= ps2c_meta;
      ps2d_meta <= ps2d;
      ps2d_s    <= ps2d_meta;
      filter_q  <= {filter_q[FILTER_LEN-2:0], ps2c_s};
      f_ps2c_q  <= f_ps2c_d;
    end
  end

  always_comb begin
    f_ps2c_d = f_ps2c_q;
    if (&filter_q) begin
      f_ps2c_d = 1'b1;
    end else if (~|filter_q) begin
      f_ps2c_d = 1'b0;
    end
  end

  assign fall_edge = f_ps2c_q & ~f_ps2c_d;

  // Frame FSM
  state_e           state_q, state_d;
  logic [3:0]       bit_cnt_q, bit_cnt_d;
  logic [9:0]       shreg_q, shreg_d;
  logic [CNT_W-1:0] wd_q, wd_d;
  logic             push;
  logic             pop;
  logic             full_int;
  logic             empty_int;
  logic             parity_err_c, frame_err_c, timeout_err_c, overflow_c;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q   <= StIdle;
      bit_cnt_q <= '0;
      shreg_q   <= '0;
      wd_q      <= '0;
    end else begin
      state_q   <= state_d;
      bit_cnt_q <= bit_cnt_d;
      shreg_q   <= shreg_d;
      wd_q      <= wd_d;
    end
  end

  always_comb begin
    state_d       = state_q;
    bit_cnt_d     = bit_cnt_q;
    shreg_d       = shreg_q;
    wd_d          = wd_q;
    push          = 1'b0;
    parity_err_c  = 1'b0;
    frame_err_c   = 1'b0;
    timeout_err_c = 1'b0;
    overflow_c    = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (fall_edge && bus.rx_en && !ps2d_s) begin
          state_d   = StData;
          bit_cnt_d = '0;
          wd_d      = '0;
        end
      end
      StData: begin
        if (fall_edge) begin
          // Shift in from the top so the LSB-first byte lands in shreg[7:0]
          shreg_d   = {ps2d_s, shreg_q[9:1]};
          bit_cnt_d = bit_cnt_q + 4'd1;
          wd_d      = '0;
          if (bit_cnt_q == 4'd9) begin
            state_d = StCheck;
          end
        end else if (wd_q == CNT_W'(TIMEOUT_CYC - 1)) begin
          timeout_err_c = 1'b1;
          state_d       = StIdle;
        end else begin
          wd_d = wd_q + 1'b1;
        end
      end
      StCheck: begin
        state_d = StIdle;
        if (!shreg_q[9]) begin
          frame_err_c = 1'b1;
        end else if (!(^shreg_q[8:0])) begin
          parity_err_c = 1'b1;
        end else if (full_int) begin
          overflow_c = 1'b1;
        end else begin
          push = 1'b1;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  // Show-ahead receive FIFO
  logic [7:0]       mem [FIFO_DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, rd_ptr_q;
  logic [OCC_W-1:0] occ_q, occ_d;

  assign full_int  = (occ_q == OCC_W'(FIFO_DEPTH));
  assign empty_int = (occ_q == '0);
  assign pop       = bus.rd_en & ~empty_int;

  always_comb begin
    occ_d = occ_q;
    unique case ({push, pop})
      2'b10:   occ_d = occ_q + 1'b1;
      2'b01:   occ_d = occ_q - 1'b1;
      default: occ_d = occ_q;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      occ_q    <= '0;
    end else begin
      occ_q <= occ_d;
      if (push) begin
        wr_ptr_q <= wr_ptr_q + 1'b1;
      end
      if (pop) begin
        rd_ptr_q <= rd_ptr_q + 1'b1;
      end
    end
  end

  // Storage needs no reset: dout is gated by empty
  always_ff @(posedge clk) begin
    if (push) begin
      mem[wr_ptr_q] <= shreg_q[7:0];
    end
  end

  assign bus.dout        = empty_int ? 8'h00 : mem[rd_ptr_q];
  assign bus.empty       = empty_int;
  assign bus.full        = full_int;
  assign bus.rx_busy     = (state_q != StIdle);
  assign bus.parity_err  = parity_err_c;
  assign bus.frame_err   = frame_err_c;
  assign bus.timeout_err = timeout_err_c;
  assign bus.overflow    = overflow_c;

endmodule

// File: tb/tb_ps2_rx_fifo.sv
// Directed bench for ps2_rx_fifo: good, bad-parity, bad-stop and truncated frames, FIFO fill,
// overflow and drain, reset mid-frame and sub-window clock glitches.
module tb_ps2_rx_fifo;

  localparam int unsigned FilterLen  = 8;
  localparam int unsigned TimeoutCyc = 1000;
  localparam int unsigned Half       = 20;

  logic clk = 1'b0;
  logic reset = 1'b1;
  logic ps2c = 1'b1;
  logic ps2d = 1'b1;

  ps2_rx_fifo_if bus ();

  ps2_rx_fifo #(
    .FILTER_LEN  (FilterLen),
    .TIMEOUT_CYC (TimeoutCyc),
    .FIFO_DEPTH  (4),
    .CNT_W       (16)
  ) u_dut (
    .clk   (clk),
    .reset (reset),
    .ps2d  (ps2d),
    .ps2c  (ps2c),
    .bus   (bus.slave)
  );

  always #5 clk = ~clk;

  int n_vec = 0;
  int n_err = 0;
  int n_par = 0, n_frm = 0, n_tmo = 0, n_ovf = 0, n_busy = 0;

  // Pulse and busy-cycle tallies; the stimulus compares snapshots of these
  always @(negedge clk) begin
    if (bus.parity_err)  n_par++;
    if (bus.frame_err)   n_frm++;
    if (bus.timeout_err) n_tmo++;
    if (bus.overflow)    n_ovf++;
    if (bus.rx_busy)     n_busy++;
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic wait_cyc(input int n);
    repeat (n) @(negedge clk);
  endtask

  // Device drives data while the clock is high; host samples on the falling edge
  task automatic send_bits(input logic [10:0] f, input int nbits);
    for (int i = 0; i < nbits; i++) begin
      ps2d = f[i];
      wait_cyc(Half);
      ps2c = 1'b0;
      wait_cyc(Half);
      ps2c = 1'b1;
    end
  endtask

  function automatic logic [10:0] mk_frame(input logic [7:0] d, input logic par, input logic stp);
    return {stp, par, d, 1'b0};
  endfunction

  task automatic send_byte(input logic [7:0] d);
    send_bits(mk_frame(d, ~^d, 1'b1), 11);
    ps2d = 1'b1;
    wait_cyc(30);
  endtask

  task automatic pop;
    bus.rd_en = 1'b1;
    @(negedge clk);
    bus.rd_en = 1'b0;
  endtask

  int s_par, s_frm, s_tmo, s_ovf, s_busy;
  logic [7:0] exp_b;

  initial begin
    bus.rx_en = 1'b1;
    bus.rd_en = 1'b0;
    wait_cyc(4);
    reset = 1'b0;
    wait_cyc(2);

    check("rst_dout", 32'(bus.dout), 32'h00);
    check("rst_empty", 32'(bus.empty), 32'd1);
    check("rst_full", 32'(bus.full), 32'd0);
    check("rst_busy", 32'(bus.rx_busy), 32'd0);
    check("rst_pulses", 32'(n_par + n_frm + n_tmo + n_ovf), 32'd0);

    // Good frame 0x1C: three ones, so odd parity bit is 0
    send_bits(mk_frame(8'h1C, 1'b0, 1'b1), 11);
    wait_cyc(30);
    check("t1_empty", 32'(bus.empty), 32'd0);
    check("t1_dout", 32'(bus.dout), 32'h1C);
    check("t1_pulses", 32'(n_par + n_frm + n_tmo + n_ovf), 32'd0);
    check("t1_busy", 32'(bus.rx_busy), 32'd0);
    pop();
    check("t1_pop_empty", 32'(bus.empty), 32'd1);
    check("t1_pop_dout", 32'(bus.dout), 32'h00);

    // Bad parity
    send_bits(mk_frame(8'h1C, 1'b1, 1'b1), 11);
    wait_cyc(30);
    check("t2_par_err", 32'(n_par), 32'd1);
    check("t2_empty", 32'(bus.empty), 32'd1);

    // Bad stop bit outranks parity
    send_bits(mk_frame(8'h1C, 1'b0, 1'b0), 11);
    ps2d = 1'b1;
    wait_cyc(30);
    check("t3_frm_err", 32'(n_frm), 32'd1);
    check("t3_par_err", 32'(n_par), 32'd1);
    check("t3_empty", 32'(bus.empty), 32'd1);

    // Start plus four data bits, then the clock stalls
    send_bits(mk_frame(8'hF0, 1'b1, 1'b1), 5);
    wait_cyc(2);
    check("t4_busy_mid", 32'(bus.rx_busy), 32'd1);
    wait_cyc(TimeoutCyc + 20);
    check("t4_tmo_err", 32'(n_tmo), 32'd1);
    check("t4_busy", 32'(bus.rx_busy), 32'd0);
    check("t4_empty", 32'(bus.empty), 32'd1);
    send_byte(8'hF0);
    check("t4_dout", 32'(bus.dout), 32'hF0);
    check("t4_tmo_once", 32'(n_tmo), 32'd1);
    pop();

    // Fill, overflow, drain
    for (int i = 1; i <= 4; i++) send_byte(8'(i));
    check("t5_full", 32'(bus.full), 32'd1);
    check("t5_head", 32'(bus.dout), 32'h01);
    send_byte(8'h05);
    check("t5_ovf", 32'(n_ovf), 32'd1);
    check("t5_full2", 32'(bus.full), 32'd1);
    for (int i = 1; i <= 4; i++) begin
      exp_b = 8'(i);
      check($sformatf("t5_pop%0d", i), 32'(bus.dout), 32'(exp_b));
      pop();
    end
    check("t5_empty", 32'(bus.empty), 32'd1);
    check("t5_full_clr", 32'(bus.full), 32'd0);

    // Reset mid-frame with a byte already buffered
    send_byte(8'h33);
    check("t6_pre_dout", 32'(bus.dout), 32'h33);
    send_bits(mk_frame(8'hA5, 1'b1, 1'b1), 4);
    wait_cyc(2);
    check("t6_pre_busy", 32'(bus.rx_busy), 32'd1);
    s_par = n_par; s_frm = n_frm; s_tmo = n_tmo; s_ovf = n_ovf;
    reset = 1'b1;
    wait_cyc(1);
    check("t6_rst_busy", 32'(bus.rx_busy), 32'd0);
    check("t6_rst_empty", 32'(bus.empty), 32'd1);
    check("t6_rst_dout", 32'(bus.dout), 32'h00);
    check("t6_rst_full", 32'(bus.full), 32'd0);
    wait_cyc(4);
    reset = 1'b0;
    wait_cyc(4);

    // Clock glitches shorter than the filter window, with data held low as a start bit
    ps2d = 1'b0;
    s_busy = n_busy;
    for (int g = 0; g < 8; g++) begin
      ps2c = 1'b0;
      wait_cyc(FilterLen - 2);
      ps2c = 1'b1;
      wait_cyc(10);
    end
    wait_cyc(20);
    check("t6_glitch_busy", 32'(n_busy - s_busy), 32'd0);
    check("t6_no_pulses", 32'((n_par - s_par) + (n_frm - s_frm) + (n_tmo - s_tmo)
                              + (n_ovf - s_ovf)), 32'd0);
    ps2d = 1'b1;
    wait_cyc(10);
    send_byte(8'h5A);
    check("t6_dout", 32'(bus.dout), 32'h5A);
    check("t6_empty", 32'(bus.empty), 32'd0);
    pop();
    check("t6_final_empty", 32'(bus.empty), 32'd1);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
